data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory interface: the single-cycle core drives `MEM_*` length, sign, address and data signals; this block serves them.
- Byte-lane RAM with combinational (same-cycle) reads and synchronous writes.
- Handles alignment and range checking, and reports faults through sticky status outputs.
- Sits beside the instruction memory at top level and replaces the plain data-memory array.

---
 rtl/data_mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory interface: byte-lane RAM, alignment/range checks, sticky faults.
// Optional define DMEM_CYCLE_COUNTER_EN maps a free-running 32-bit cycle counter at CYCLE_ADDR.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] CYCLE_ADDR  = 32'hFFFF_FFF0
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [1:0]  MEM_write_length,
  input  logic [1:0]  MEM_read_length,
  input  logic        MEM_read_signed,
  input  logic [31:0] MEM_write_data,
  input  logic [31:0] MEM_write_address,
  input  logic [31:0] MEM_read_address,
  output logic [31:0] MEM_read_data,
  output logic        MEM_fault,
  output logic [31:0] MEM_fault_address,
  output logic [7:0]  MEM_fault_count
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  logic [31:0] ram_q [DEPTH_WORDS];

  logic [31:0]   rd_off_c;
  logic [31:0]   wr_off_c;
  logic [AW-1:0] rd_idx_c;
  logic [AW-1:0] wr_idx_c;
  logic          rd_ctr_hit_c;
  logic          wr_ctr_hit_c;
  logic          rd_ram_ok_c;
  logic          wr_ram_ok_c;
  logic          rd_ctr_ok_c;
  logic          wr_ctr_ok_c;
  logic          rd_fault_c;
  logic          wr_fault_c;
  logic [3:0]    wr_be_c;
  logic [31:0]   wr_lanes_c;
  logic [31:0]   rd_word_c;
  logic [31:0]   rd_data_c;
  logic [31:0]   cycle_val_c;

  logic        fault_q,      fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [7:0]  fault_cnt_q,  fault_cnt_d;
  logic [8:0]  cnt_sum_c;

  function automatic logic is_aligned(input logic [1:0] len, input logic [1:0] lo);
    logic ok;
    ok = 1'b1;
    case (len)
      LEN_HALF: ok = ~lo[0];
      LEN_WORD: ok = (lo == 2'b00);
      default:  ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Lane select plus sign/zero extension of a loaded word.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] len,
                                               input logic [1:0] lo, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (len)
      LEN_BYTE: r = {{24{sgn & b[7]}}, b};
      LEN_HALF: r = {{16{sgn & h[15]}}, h};
      LEN_WORD: r = w;
      default:  r = 32'h0;
    endcase
    return r;
  endfunction

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    rd_ctr_hit_c = (MEM_read_address[31:2] == CYCLE_ADDR[31:2]);
    wr_ctr_hit_c = (MEM_write_address[31:2] == CYCLE_ADDR[31:2]);
    cycle_val_c  = cycle_q;
  end

  // A word store to the counter preempts the increment on that edge.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (wr_ctr_ok_c) begin
      cycle_d = MEM_write_data;
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      cycle_q <= 32'h0;
    end else begin
      cycle_q <= cycle_d;
    end
  end
`else
  logic unused_cycle_addr;

  always_comb begin
    rd_ctr_hit_c = 1'b0;
    wr_ctr_hit_c = 1'b0;
    cycle_val_c  = 32'h0;
  end

  assign unused_cycle_addr = ^CYCLE_ADDR;
`endif

  // Address decode, alignment and range classification for both ports.
  always_comb begin
    rd_off_c    = MEM_read_address - BASE_ADDR;
    wr_off_c    = MEM_write_address - BASE_ADDR;
    rd_idx_c    = rd_off_c[AW+1:2];
    wr_idx_c    = wr_off_c[AW+1:2];
    rd_ram_ok_c = (rd_off_c < SPAN) && !rd_ctr_hit_c
                  && is_aligned(MEM_read_length, MEM_read_address[1:0]);
    wr_ram_ok_c = (wr_off_c < SPAN) && !wr_ctr_hit_c
                  && is_aligned(MEM_write_length, MEM_write_address[1:0]);
    rd_ctr_ok_c = rd_ctr_hit_c && (MEM_read_length == LEN_WORD)
                  && (MEM_read_address[1:0] == 2'b00);
    wr_ctr_ok_c = wr_ctr_hit_c && (MEM_write_length == LEN_WORD)
                  && (MEM_write_address[1:0] == 2'b00);
    rd_fault_c  = (MEM_read_length != LEN_NONE) && !(rd_ram_ok_c || rd_ctr_ok_c);
    wr_fault_c  = (MEM_write_length != LEN_NONE) && !(wr_ram_ok_c || wr_ctr_ok_c);
  end

  // Store lane enables and lane-replicated store data.
  always_comb begin
    wr_be_c    = 4'b0000;
    wr_lanes_c = MEM_write_data;
    case (MEM_write_length)
      LEN_BYTE: begin
        wr_be_c    = 4'b0001 << MEM_write_address[1:0];
        wr_lanes_c = {4{MEM_write_data[7:0]}};
      end
      LEN_HALF: begin
        wr_be_c    = MEM_write_address[1] ? 4'b1100 : 4'b0011;
        wr_lanes_c = {2{MEM_write_data[15:0]}};
      end
      LEN_WORD: begin
        wr_be_c    = 4'b1111;
        wr_lanes_c = MEM_write_data;
      end
      default: begin
        wr_be_c    = 4'b0000;
        wr_lanes_c = MEM_write_data;
      end
    endcase
    if (!wr_ram_ok_c) begin
      wr_be_c = 4'b0000;
    end
  end

  // Storage is not reset; stores are blocked while reset is held.
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be_c[l]) begin
          ram_q[wr_idx_c][8*l +: 8] <= wr_lanes_c[8*l +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word_c = ram_q[rd_idx_c];
    rd_data_c = 32'h0;
    if (rd_ram_ok_c) begin
      rd_data_c = load_extract(rd_word_c, MEM_read_length, MEM_read_address[1:0],
                               MEM_read_signed);
    end else if (rd_ctr_ok_c) begin
      rd_data_c = cycle_val_c;
    end
  end

  assign MEM_read_data = SYS_reset ? 32'h0 : rd_data_c;

  // Sticky fault flag, first-fault address (store wins a tie), saturating count.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    cnt_sum_c    = 9'(fault_cnt_q) + 9'(rd_fault_c) + 9'(wr_fault_c);
    fault_cnt_d  = cnt_sum_c[8] ? 8'hFF : cnt_sum_c[7:0];
    if (rd_fault_c || wr_fault_c) begin
      fault_d = 1'b1;
      if (!fault_q) begin
        fault_addr_d = wr_fault_c ? MEM_write_address : MEM_read_address;
      end
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      fault_cnt_q  <= 8'h0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign MEM_fault         = fault_q;
  assign MEM_fault_address = fault_addr_q;
  assign MEM_fault_count   = fault_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table, hand sequences, randomized run vs byte-level model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] CADDR = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wl, rl;
  logic        rs;
  logic [31:0] wd, wa, ra;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] faddr;
  logic [7:0]  fcnt;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .SYS_clk          (clk),
    .SYS_reset        (rst),
    .MEM_write_length (wl),
    .MEM_read_length  (rl),
    .MEM_read_signed  (rs),
    .MEM_write_data   (wd),
    .MEM_write_address(wa),
    .MEM_read_address (ra),
    .MEM_read_data    (rdata),
    .MEM_fault        (fault),
    .MEM_fault_address(faddr),
    .MEM_fault_count  (fcnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: flat byte array plus fault status.
  logic [7:0]  mbytes [DEPTH*4];
  logic        m_fault = 1'b0;
  logic [31:0] m_faddr = 32'h0;
  int          m_fcnt  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : (len == 2'd3) ? 4 : 0;
  endfunction

  function automatic bit acc_ok(input logic [1:0] len, input logic [31:0] a);
    logic [31:0] off;
    int n;
    n   = nbytes(len);
    off = a - BASE;
    return (off < 32'(DEPTH*4)) && ((a % 32'(n)) == 32'd0);
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] v;
    int n;
    int off;
    if (rst || rl == 2'd0 || !acc_ok(rl, ra)) return 32'h0;
    n   = nbytes(rl);
    off = int'(ra - BASE);
    v   = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mbytes[off+i]) << (8*i));
    if (rs && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  function automatic void model_edge();
    bit rf, wf;
    int off;
    if (rst) begin
      m_fault = 1'b0; m_faddr = 32'h0; m_fcnt = 0;
      return;
    end
    rf = (rl != 2'd0) && !acc_ok(rl, ra);
    wf = (wl != 2'd0) && !acc_ok(wl, wa);
    if (rf || wf) begin
      if (!m_fault) m_faddr = wf ? wa : ra;
      m_fault = 1'b1;
    end
    m_fcnt = m_fcnt + int'(rf) + int'(wf);
    if (m_fcnt > 255) m_fcnt = 255;
    if (wl != 2'd0 && !wf) begin
      off = int'(wa - BASE);
      for (int i = 0; i < nbytes(wl); i++) mbytes[off+i] = 8'(wd >> (8*i));
    end
  endfunction

  // One clock: drive at negedge, check comb read, then check status after the edge.
  task automatic cycle(input logic r, input logic [1:0] w_len, input logic [1:0] r_len,
                       input logic sgn, input logic [31:0] w_data, input logic [31:0] w_addr,
                       input logic [31:0] r_addr, input bit chk, output logic [31:0] rd_seen);
    @(negedge clk);
    rst = r; wl = w_len; rl = r_len; rs = sgn; wd = w_data; wa = w_addr; ra = r_addr;
    #1;
    rd_seen = rdata;
    if (chk) check("read_data", rdata, model_read());
    @(posedge clk);
    model_edge();
    #1;
    if (chk) begin
      check("fault", {31'b0, fault}, {31'b0, m_fault});
      check("fault_addr", faddr, m_faddr);
      check("fault_count", {24'b0, fcnt}, 32'(m_fcnt));
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  w_len;
    logic [1:0]  r_len;
    logic        sgn;
    logic [31:0] w_data;
    logic [31:0] w_addr;
    logic [31:0] r_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    rst = 1'b1; wl = 2'd0; rl = 2'd3; rs = 1'b0; wd = 32'h0; wa = 32'h0; ra = 32'h10;
    #3;
    check("rst_read_data", rdata, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_fault_addr", faddr, 32'h0);
    check("rst_fault_count", {24'b0, fcnt}, 32'h0);

    // Zero the whole RAM so the model starts from known contents.
    for (int w = 0; w < int'(DEPTH); w++) cycle(1'b0, 2'd3, 2'd0, 1'b0, 32'h0, 32'(w*4), 32'h0, 1'b0, rd);
    cycle(1'b0, 2'd3, 2'd0, 1'b0, 32'h8BADF00D, 32'h10, 32'h0, 1'b1, rd);

    tbl[0]  = '{"lw_10",   2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h10, 32'h8BADF00D};
    tbl[1]  = '{"lb_13",   2'd0, 2'd1, 1'b1, 32'h0, 32'h0, 32'h13, 32'hFFFFFF8B};
    tbl[2]  = '{"lbu_12",  2'd0, 2'd1, 1'b0, 32'h0, 32'h0, 32'h12, 32'h000000AD};
    tbl[3]  = '{"lh_12",   2'd0, 2'd2, 1'b1, 32'h0, 32'h0, 32'h12, 32'hFFFF8BAD};
    tbl[4]  = '{"lhu_10",  2'd0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h10, 32'h0000F00D};
    tbl[5]  = '{"lb_10",   2'd0, 2'd1, 1'b1, 32'h0, 32'h0, 32'h10, 32'h0000000D};
    tbl[6]  = '{"lh_10",   2'd0, 2'd2, 1'b1, 32'h0, 32'h0, 32'h10, 32'hFFFFF00D};
    tbl[7]  = '{"lbu_11",  2'd0, 2'd1, 1'b0, 32'h0, 32'h0, 32'h11, 32'h000000F0};
    tbl[8]  = '{"rl_none", 2'd0, 2'd0, 1'b1, 32'h0, 32'h0, 32'h10, 32'h00000000};
    tbl[9]  = '{"lw_14",   2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h14, 32'h00000000};
    tbl[10] = '{"sw_lw_ffc", 2'd3, 2'd3, 1'b0, 32'hCAFEBABE, 32'hFFC, 32'hFFC, 32'h00000000};
    tbl[11] = '{"lw_ffc",  2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'hFFC, 32'hCAFEBABE};
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, tbl[i].w_len, tbl[i].r_len, tbl[i].sgn, tbl[i].w_data, tbl[i].w_addr,
            tbl[i].r_addr, 1'b1, rd);
      check(tbl[i].name, rd, tbl[i].exp_rd);
    end

    // Byte store into a stored word, then the fault sequence up to saturation.
    cycle(1'b0, 2'd1, 2'd0, 1'b0, 32'h0000007F, 32'h11, 32'h0, 1'b1, rd);
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h10, 1'b1, rd);
    check("sb_merge", rd, 32'h8BAD7F0D);
    check("sb_no_fault", {31'b0, fault}, 32'h0);
    cycle(1'b0, 2'd2, 2'd0, 1'b0, 32'h0000BEEF, 32'h11, 32'h0, 1'b1, rd);
    check("sh_mis_fault", {31'b0, fault}, 32'h1);
    check("sh_mis_addr", faddr, 32'h11);
    check("sh_mis_count", {24'b0, fcnt}, 32'd1);
    cycle(1'b0, 2'd3, 2'd3, 1'b0, 32'h12345678, 32'h22, 32'h10, 1'b1, rd);
    check("sh_unchanged", rd, 32'h8BAD7F0D);
    check("sw_mis_addr", faddr, 32'h11);
    check("sw_mis_count", {24'b0, fcnt}, 32'd2);
    cycle(1'b0, 2'd2, 2'd3, 1'b0, 32'h0, 32'h13, 32'h1000, 1'b1, rd);
    check("oor_read_zero", rd, 32'h0);
    check("dual_count", {24'b0, fcnt}, 32'd4);
    for (int i = 0; i < 250; i++) cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h2, 1'b1, rd);
    check("count_254", {24'b0, fcnt}, 32'd254);
    cycle(1'b0, 2'd3, 2'd2, 1'b0, 32'h0, 32'h1, 32'h1, 1'b1, rd);
    check("count_sat", {24'b0, fcnt}, 32'd255);
    cycle(1'b0, 2'd3, 2'd2, 1'b0, 32'h0, 32'h1, 32'h1, 1'b1, rd);
    check("count_hold", {24'b0, fcnt}, 32'd255);

    // Reset asserted between edges clears status immediately.
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h10, 1'b1, rd);
    @(posedge clk); #2; rst = 1'b1; #1;
    m_fault = 1'b0; m_faddr = 32'h0; m_fcnt = 0;
    check("midrst_fault", {31'b0, fault}, 32'h0);
    check("midrst_count", {24'b0, fcnt}, 32'h0);
    check("midrst_addr", faddr, 32'h0);
    check("midrst_read", rdata, 32'h0);
    cycle(1'b1, 2'd3, 2'd0, 1'b0, 32'hDEADBEEF, 32'h80, 32'h0, 1'b1, rd);
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h80, 1'b1, rd);
    check("rst_write_blocked", rd, 32'h0);
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h1000, 1'b1, rd);
    check("lw_1000_addr", faddr, 32'h1000);
    check("lw_1000_fault", {31'b0, fault}, 32'h1);

    // Same-edge read and write fault after reset: store address wins.
    cycle(1'b1, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, rd);
    cycle(1'b0, 2'd2, 2'd3, 1'b0, 32'h0, 32'h2002, 32'h3, 1'b1, rd);
    check("prio_addr", faddr, 32'h2002);
    check("prio_count", {24'b0, fcnt}, 32'd2);

    // Store and load of one word on the same edge.
    cycle(1'b0, 2'd3, 2'd3, 1'b0, 32'h11223344, 32'h40, 32'h40, 1'b1, rd);
    check("raw_old", rd, 32'h0);
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h40, 1'b1, rd);
    check("raw_new", rd, 32'h11223344);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a1, a2;
      a1 = (($urandom % 4) == 0) ? (32'hFF0 + ($urandom % 32'h30)) : ($urandom % 32'h80);
      a2 = (($urandom % 4) == 0) ? (32'hFF0 + ($urandom % 32'h30)) : ($urandom % 32'h80);
      cycle(1'b0, 2'($urandom % 4), 2'($urandom % 4), 1'($urandom % 2), $urandom, a1, a2, 1'b1, rd);
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    cycle(1'b0, 2'd3, 2'd0, 1'b0, 32'hFFFFFFFE, CADDR, 32'h0, 1'b0, rd);
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, CADDR, 1'b0, rd);
    check("ctr_0", rd, 32'hFFFFFFFE);
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, CADDR, 1'b0, rd);
    check("ctr_1", rd, 32'hFFFFFFFF);
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, CADDR, 1'b0, rd);
    check("ctr_wrap", rd, 32'h00000000);
    cycle(1'b0, 2'd0, 2'd1, 1'b0, 32'h0, 32'h0, CADDR, 1'b0, rd);
    check("ctr_byte_zero", rd, 32'h0);
`else
    cycle(1'b0, 2'd0, 2'd3, 1'b0, 32'h0, 32'h0, CADDR, 1'b1, rd);
    check("caddr_plain_zero", rd, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
